// File: rtl/rx_frame_checker.sv
// UART RX frame checker: assembles LSB-first data from voted sampler bits,
// checks parity and stop bits, and keeps saturating error counters.
module rx_frame_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            cfg_data_bits,
  input  logic                  cfg_par_en,
  input  logic [1:0]            cfg_par_mode,
  input  logic                  cfg_stop2,
  input  logic                  frame_start,
  input  logic                  bit_valid,
  input  logic                  sampled_bit,
  input  logic                  frame_abort,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  frm_err,
  output logic                  busy,
  output logic [ERR_CNT_W-1:0]  par_err_cnt,
  output logic [ERR_CNT_W-1:0]  frm_err_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP1  = 3'd3,
    STOP2  = 3'd4
  } state_t;

  localparam logic [3:0]           MAX_BITS = 4'(DATA_WIDTH);
  localparam logic [3:0]           MIN_BITS = 4'd5;
  localparam logic [ERR_CNT_W-1:0] CNT_MAX  = {ERR_CNT_W{1'b1}};

  state_t                state_q, state_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  par_acc_q, par_acc_d;
  logic                  par_flag_q, par_flag_d;
  logic                  frm_flag_q, frm_flag_d;
  logic [3:0]            cfg_bits_q, cfg_bits_d;
  logic                  cfg_par_en_q, cfg_par_en_d;
  logic [1:0]            cfg_par_mode_q, cfg_par_mode_d;
  logic                  cfg_stop2_q, cfg_stop2_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_q, par_err_d;
  logic                  frm_err_q, frm_err_d;
  logic [ERR_CNT_W-1:0]  par_cnt_q, par_cnt_d;
  logic [ERR_CNT_W-1:0]  frm_cnt_q, frm_cnt_d;

  logic [3:0] bits_clamped;
  logic       par_expected;
  logic       frm_now;
  logic       done;

  always_comb begin
    bits_clamped = cfg_data_bits;
    if (cfg_data_bits < MIN_BITS) begin
      bits_clamped = MIN_BITS;
    end else if (cfg_data_bits > MAX_BITS) begin
      bits_clamped = MAX_BITS;
    end
  end

  always_comb begin
    case (cfg_par_mode_q)
      2'b00:   par_expected = par_acc_q;
      2'b01:   par_expected = ~par_acc_q;
      2'b10:   par_expected = 1'b1;
      default: par_expected = 1'b0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shreg_d        = shreg_q;
    par_acc_d      = par_acc_q;
    par_flag_d     = par_flag_q;
    frm_flag_d     = frm_flag_q;
    cfg_bits_d     = cfg_bits_q;
    cfg_par_en_d   = cfg_par_en_q;
    cfg_par_mode_d = cfg_par_mode_q;
    cfg_stop2_d    = cfg_stop2_q;
    rx_data_d      = rx_data_q;
    data_valid_d   = 1'b0;
    par_err_d      = par_err_q;
    frm_err_d      = frm_err_q;
    frm_now        = frm_flag_q | ~sampled_bit;
    done           = 1'b0;

    if (state_q == IDLE) begin
      if (frame_start) begin
        state_d        = DATA;
        bit_cnt_d      = 4'd0;
        shreg_d        = '0;
        par_acc_d      = 1'b0;
        par_flag_d     = 1'b0;
        frm_flag_d     = 1'b0;
        par_err_d      = 1'b0;
        frm_err_d      = 1'b0;
        cfg_bits_d     = bits_clamped;
        cfg_par_en_d   = cfg_par_en;
        cfg_par_mode_d = cfg_par_mode;
        cfg_stop2_d    = cfg_stop2;
      end
    end else if (frame_abort) begin
      state_d = IDLE;
    end else if (bit_valid) begin
      case (state_q)
        DATA: begin
          // Bits land at their final position, so the word is already right-aligned.
          shreg_d   = shreg_q | (DATA_WIDTH'(sampled_bit) << bit_cnt_q);
          par_acc_d = par_acc_q ^ sampled_bit;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q + 4'd1 == cfg_bits_q) begin
            state_d = cfg_par_en_q ? PARITY : STOP1;
          end
        end
        PARITY: begin
          if (sampled_bit != par_expected) begin
            par_flag_d = 1'b1;
          end
          state_d = STOP1;
        end
        STOP1: begin
          if (cfg_stop2_q) begin
            frm_flag_d = frm_now;
            state_d    = STOP2;
          end else begin
            done = 1'b1;
          end
        end
        STOP2: begin
          done = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    if (done) begin
      state_d      = IDLE;
      data_valid_d = 1'b1;
      rx_data_d    = shreg_q;
      par_err_d    = par_flag_q;
      frm_err_d    = frm_now;
    end
  end

  // Clear beats a same-cycle increment; counters stick at all-ones.
  always_comb begin
    par_cnt_d = par_cnt_q;
    frm_cnt_d = frm_cnt_q;
    if (err_clr) begin
      par_cnt_d = '0;
      frm_cnt_d = '0;
    end else if (done) begin
      if (par_flag_q && par_cnt_q != CNT_MAX) begin
        par_cnt_d = par_cnt_q + ERR_CNT_W'(1);
      end
      if (frm_now && frm_cnt_q != CNT_MAX) begin
        frm_cnt_d = frm_cnt_q + ERR_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      bit_cnt_q      <= 4'd0;
      shreg_q        <= '0;
      par_acc_q      <= 1'b0;
      par_flag_q     <= 1'b0;
      frm_flag_q     <= 1'b0;
      cfg_bits_q     <= MIN_BITS;
      cfg_par_en_q   <= 1'b0;
      cfg_par_mode_q <= 2'b00;
      cfg_stop2_q    <= 1'b0;
      rx_data_q      <= '0;
      data_valid_q   <= 1'b0;
      par_err_q      <= 1'b0;
      frm_err_q      <= 1'b0;
      par_cnt_q      <= '0;
      frm_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shreg_q        <= shreg_d;
      par_acc_q      <= par_acc_d;
      par_flag_q     <= par_flag_d;
      frm_flag_q     <= frm_flag_d;
      cfg_bits_q     <= cfg_bits_d;
      cfg_par_en_q   <= cfg_par_en_d;
      cfg_par_mode_q <= cfg_par_mode_d;
      cfg_stop2_q    <= cfg_stop2_d;
      rx_data_q      <= rx_data_d;
      data_valid_q   <= data_valid_d;
      par_err_q      <= par_err_d;
      frm_err_q      <= frm_err_d;
      par_cnt_q      <= par_cnt_d;
      frm_cnt_q      <= frm_cnt_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign data_valid  = data_valid_q;
  assign par_err     = par_err_q;
  assign frm_err     = frm_err_q;
  assign busy        = (state_q != IDLE);
  assign par_err_cnt = par_cnt_q;
  assign frm_err_cnt = frm_cnt_q;

endmodule

// File: tb/tb_rx_frame_checker.sv
// Directed self-checking bench for rx_frame_checker, built with 2-bit
// error counters so saturation is reachable in a few frames.
module tb_rx_frame_checker;

  localparam int DW = 8;
  localparam int EW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    cfg_data_bits;
  logic          cfg_par_en;
  logic [1:0]    cfg_par_mode;
  logic          cfg_stop2;
  logic          frame_start;
  logic          bit_valid;
  logic          sampled_bit;
  logic          frame_abort;
  logic          err_clr;
  logic [DW-1:0] rx_data;
  logic          data_valid;
  logic          par_err;
  logic          frm_err;
  logic          busy;
  logic [EW-1:0] par_err_cnt;
  logic [EW-1:0] frm_err_cnt;

  int checks   = 0;
  int errors   = 0;
  int dv_count = 0;

  rx_frame_checker #(.DATA_WIDTH(DW), .ERR_CNT_W(EW)) dut (
    .clk(clk), .rst(rst),
    .cfg_data_bits(cfg_data_bits), .cfg_par_en(cfg_par_en),
    .cfg_par_mode(cfg_par_mode), .cfg_stop2(cfg_stop2),
    .frame_start(frame_start), .bit_valid(bit_valid),
    .sampled_bit(sampled_bit), .frame_abort(frame_abort), .err_clr(err_clr),
    .rx_data(rx_data), .data_valid(data_valid), .par_err(par_err),
    .frm_err(frm_err), .busy(busy),
    .par_err_cnt(par_err_cnt), .frm_err_cnt(frm_err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (data_valid) dv_count++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // cfg is scrambled right after the start pulse so the frame relies on the latched copy
  task automatic start_frame(input logic [3:0] bits, input logic pen,
                             input logic [1:0] mode, input logic s2);
    cfg_data_bits = bits;
    cfg_par_en    = pen;
    cfg_par_mode  = mode;
    cfg_stop2     = s2;
    frame_start   = 1'b1;
    tick();
    frame_start   = 1'b0;
    cfg_data_bits = 4'd6;
    cfg_par_en    = ~pen;
    cfg_par_mode  = ~mode;
    cfg_stop2     = ~s2;
  endtask

  task automatic send_bit(input logic b);
    bit_valid   = 1'b1;
    sampled_bit = b;
    tick();
    bit_valid   = 1'b0;
    sampled_bit = 1'b0;
  endtask

  task automatic send_data(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) send_bit(d[i]);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) tick();
    checks++;
    if ({rx_data, data_valid, par_err, frm_err, busy, par_err_cnt, frm_err_cnt} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got rx=%h dv=%b pe=%b fe=%b busy=%b pc=%0d fc=%0d want all 0",
               rx_data, data_valid, par_err, frm_err, busy, par_err_cnt, frm_err_cnt);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_even_parity();
    start_frame(4'd8, 1'b1, 2'b00, 1'b0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL even_busy_rise: got %b want 1", busy); end
    send_data(8'hA5, 8);
    send_bit(1'b0);
    send_bit(1'b1);
    checks++;
    if ({data_valid, busy} !== 2'b10) begin
      errors++; $display("[TB] FAIL even_dv_busy: got dv=%b busy=%b want dv=1 busy=0", data_valid, busy);
    end
    checks++;
    if ({rx_data, par_err, frm_err} !== {8'hA5, 2'b00}) begin
      errors++; $display("[TB] FAIL even_word: got rx=%h pe=%b fe=%b want rx=a5 pe=0 fe=0", rx_data, par_err, frm_err);
    end
    tick();
    checks++;
    if ({data_valid, rx_data} !== {1'b0, 8'hA5}) begin
      errors++; $display("[TB] FAIL even_pulse_hold: got dv=%b rx=%h want dv=0 rx=a5", data_valid, rx_data);
    end
  endtask

  task automatic test_odd_parity_error();
    start_frame(4'd8, 1'b1, 2'b01, 1'b0);
    send_data(8'hA5, 8);
    send_bit(1'b0);
    send_bit(1'b1);
    checks++;
    if ({data_valid, par_err, frm_err, par_err_cnt, frm_err_cnt} !== {3'b110, 2'd1, 2'd0}) begin
      errors++;
      $display("[TB] FAIL odd_perr: got dv=%b pe=%b fe=%b pc=%0d fc=%0d want dv=1 pe=1 fe=0 pc=1 fc=0",
               data_valid, par_err, frm_err, par_err_cnt, frm_err_cnt);
    end
    tick();
  endtask

  task automatic test_five_bit_two_stop();
    start_frame(4'd5, 1'b0, 2'b00, 1'b1);
    checks++;
    if (par_err !== 1'b0) begin errors++; $display("[TB] FAIL start_clears_perr: got %b want 0", par_err); end
    send_data(8'h13, 5);
    send_bit(1'b1);
    checks++;
    if (data_valid !== 1'b0) begin errors++; $display("[TB] FAIL stop2_early_dv: got %b want 0", data_valid); end
    send_bit(1'b0);
    checks++;
    if ({data_valid, rx_data, par_err, frm_err, par_err_cnt, frm_err_cnt} !== {1'b1, 8'h13, 2'b01, 2'd1, 2'd1}) begin
      errors++;
      $display("[TB] FAIL five_stop2: got dv=%b rx=%h pe=%b fe=%b pc=%0d fc=%0d want dv=1 rx=13 pe=0 fe=1 pc=1 fc=1",
               data_valid, rx_data, par_err, frm_err, par_err_cnt, frm_err_cnt);
    end
    tick();
  endtask

  task automatic test_mark_space();
    start_frame(4'hF, 1'b1, 2'b10, 1'b0);
    send_data(8'h00, 8);
    send_bit(1'b1);
    send_bit(1'b1);
    checks++;
    if ({data_valid, par_err, par_err_cnt} !== {2'b10, 2'd1}) begin
      errors++; $display("[TB] FAIL mark_ok: got dv=%b pe=%b pc=%0d want dv=1 pe=0 pc=1", data_valid, par_err, par_err_cnt);
    end
    tick();
    start_frame(4'd8, 1'b1, 2'b11, 1'b0);
    send_data(8'h00, 8);
    send_bit(1'b1);
    send_bit(1'b1);
    checks++;
    if ({data_valid, par_err, frm_err, par_err_cnt} !== {3'b110, 2'd2}) begin
      errors++; $display("[TB] FAIL space_err: got dv=%b pe=%b fe=%b pc=%0d want dv=1 pe=1 fe=0 pc=2",
                         data_valid, par_err, frm_err, par_err_cnt);
    end
    tick();
  endtask

  task automatic test_abort();
    int dv_before;
    dv_before = dv_count;
    start_frame(4'd8, 1'b0, 2'b00, 1'b0);
    send_data(8'h07, 3);
    frame_abort = 1'b1;
    bit_valid   = 1'b1;
    sampled_bit = 1'b1;
    tick();
    frame_abort = 1'b0;
    bit_valid   = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_idle: got busy=%b want 0", busy); end
    // A same-cycle strobe with frame_start must not be taken as data bit 0
    bit_valid   = 1'b1;
    sampled_bit = 1'b1;
    start_frame(4'd8, 1'b0, 2'b00, 1'b0);
    bit_valid   = 1'b0;
    send_data(8'h3C, 4);
    frame_start = 1'b1;
    send_bit(1'b1);
    frame_start = 1'b0;
    send_data(8'h01, 3);
    send_bit(1'b1);
    checks++;
    if ({data_valid, rx_data, par_err, frm_err} !== {1'b1, 8'h3C, 2'b00}) begin
      errors++; $display("[TB] FAIL abort_next_frame: got dv=%b rx=%h pe=%b fe=%b want dv=1 rx=3c pe=0 fe=0",
                         data_valid, rx_data, par_err, frm_err);
    end
    tick();
    checks++;
    if (dv_count - dv_before !== 1) begin
      errors++; $display("[TB] FAIL abort_dv_count: got %0d want 1", dv_count - dv_before);
    end
    checks++;
    if ({par_err_cnt, frm_err_cnt} !== {2'd2, 2'd1}) begin
      errors++; $display("[TB] FAIL abort_counters: got pc=%0d fc=%0d want pc=2 fc=1", par_err_cnt, frm_err_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [EW-1:0] exp_cnt [4];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3};
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if ({par_err_cnt, frm_err_cnt} !== 4'd0) begin
      errors++; $display("[TB] FAIL clear: got pc=%0d fc=%0d want 0 0", par_err_cnt, frm_err_cnt);
    end
    for (int f = 0; f < 4; f++) begin
      start_frame(4'd8, 1'b1, 2'b11, 1'b0);
      send_data(8'h81, 8);
      send_bit(1'b1);
      send_bit(1'b1);
      checks++;
      if ({data_valid, par_err, par_err_cnt} !== {2'b11, exp_cnt[f]}) begin
        errors++; $display("[TB] FAIL sat_frame%0d: got dv=%b pe=%b pc=%0d want dv=1 pe=1 pc=%0d",
                           f, data_valid, par_err, par_err_cnt, exp_cnt[f]);
      end
      tick();
    end
    start_frame(4'd8, 1'b1, 2'b11, 1'b0);
    send_data(8'h81, 8);
    send_bit(1'b1);
    err_clr = 1'b1;
    send_bit(1'b1);
    err_clr = 1'b0;
    checks++;
    if ({data_valid, par_err, par_err_cnt} !== {2'b11, 2'd0}) begin
      errors++; $display("[TB] FAIL clear_wins: got dv=%b pe=%b pc=%0d want dv=1 pe=1 pc=0", data_valid, par_err, par_err_cnt);
    end
    tick();
    start_frame(4'd8, 1'b1, 2'b11, 1'b0);
    send_data(8'h81, 8);
    send_bit(1'b1);
    send_bit(1'b1);
    checks++;
    if ({rx_data, par_err_cnt} !== {8'h81, 2'd1}) begin
      errors++; $display("[TB] FAIL after_clear: got rx=%h pc=%0d want rx=81 pc=1", rx_data, par_err_cnt);
    end
    tick();
  endtask

  task automatic test_reset_mid_frame();
    int dv_before;
    dv_before = dv_count;
    start_frame(4'd8, 1'b0, 2'b00, 1'b0);
    send_data(8'h0F, 4);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({rx_data, data_valid, par_err, frm_err, busy, par_err_cnt, frm_err_cnt} !== '0) begin
      errors++;
      $display("[TB] FAIL midframe_reset: got rx=%h dv=%b pe=%b fe=%b busy=%b pc=%0d fc=%0d want all 0",
               rx_data, data_valid, par_err, frm_err, busy, par_err_cnt, frm_err_cnt);
    end
    send_data(8'hFF, 5);
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (dv_count - dv_before !== 0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL midframe_no_dv: got dv_pulses=%0d busy=%b want 0 0", dv_count - dv_before, busy);
    end
  endtask

  initial begin
    rst           = 1'b0;
    cfg_data_bits = 4'd8;
    cfg_par_en    = 1'b0;
    cfg_par_mode  = 2'b00;
    cfg_stop2     = 1'b0;
    frame_start   = 1'b0;
    bit_valid     = 1'b0;
    sampled_bit   = 1'b0;
    frame_abort   = 1'b0;
    err_clr       = 1'b0;
    test_reset();
    test_even_parity();
    test_odd_parity_error();
    test_five_bit_two_stop();
    test_mark_space();
    test_abort();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_frame_checker.md
# rx_frame_checker

Parametrised receive-side frame checker for the UART RX path. It takes oversampled-and-voted bits from the RX sampler one strobe at a time and assembles the data word LSB-first. It checks a configurable parity bit (even/odd/mark/space/none) and one or two stop bits, then delivers the word with per-frame parity and framing error flags. It also keeps saturating error counters for the SoC status registers.

## Interface
- DATA_WIDTH, 8, maximum data bits per frame (legal 5..9)
- ERR_CNT_W, 8, width of each saturating error counter
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- cfg_data_bits  in  4  data bits per frame; values <5 are treated as 5, values >DATA_WIDTH as DATA_WIDTH
- cfg_par_en  in  1  1 = frame carries a parity bit
- cfg_par_mode  in  2  00 even, 01 odd, 10 mark (expect 1), 11 space (expect 0)
- cfg_stop2  in  1  1 = two stop bits checked
- frame_start  in  1  one-cycle pulse: start bit validated by the sampler
- bit_valid  in  1  one-cycle pulse: sampled_bit holds the next frame bit
- sampled_bit  in  1  voted bit value
- frame_abort  in  1  drop the current frame
- err_clr  in  1  clear both error counters
- rx_data  out  DATA_WIDTH  received word, right-aligned, unused upper bits 0
- data_valid  out  1  one-cycle pulse: rx_data, par_err, frm_err valid
- par_err  out  1  parity mismatch in the last completed frame
- frm_err  out  1  a stop bit sampled as 0 in the last completed frame
- busy  out  1  frame in progress (state != IDLE)
- par_err_cnt  out  ERR_CNT_W  saturating count of frames with par_err
- frm_err_cnt  out  ERR_CNT_W  saturating count of frames with frm_err

## Operation
- States: IDLE, DATA, PARITY, STOP1, STOP2.
- cfg_* inputs are latched on an accepted frame_start and held for the whole frame; cfg changes mid-frame have no effect.
- IDLE
  - frame_start moves to DATA and clears the bit counter, shift register, running parity, par_err and frm_err.
  - bit_valid is ignored in IDLE, including in the same cycle as frame_start.
- DATA
  - Each bit_valid shifts sampled_bit in LSB-first, XORs it into the running parity and increments the counter.
  - After the cfg_data_bits-th bit: go to PARITY if parity is enabled, else STOP1.
- PARITY
  - The expected bit is ^data for even, ~^data for odd, 1 for mark, 0 for space.
  - On bit_valid, a mismatch sets the internal parity flag. Go to STOP1.
- STOP1
  - On bit_valid, sampled_bit = 0 sets the internal framing flag.
  - Go to STOP2 if cfg_stop2, else complete.
- STOP2
  - Same stop-bit check as STOP1, then complete.
- Complete
  - Register rx_data, par_err and frm_err, pulse data_valid and return to IDLE.
  - A counter increments only when its flag is set, and holds at 2^ERR_CNT_W-1.
- Outputs hold
  - rx_data, par_err and frm_err hold until the next accepted frame_start, at which point the error flags clear.
  - rx_data is not cleared by frame_start.
- frame_start while busy is ignored.
- frame_abort in a non-IDLE state
  - Returns to IDLE next cycle with no data_valid and no counter change.
  - Abort has priority over a same-cycle bit_valid.
  - In IDLE, frame_abort has no effect.
- err_clr zeroes both counters. A same-cycle increment is lost: clear wins.

## Timing
- Reset: state IDLE; rx_data 0; data_valid 0; par_err 0; frm_err 0; busy 0; both counters 0.
- Reset asserted mid-frame drops the frame immediately, with no data_valid.
- busy rises the cycle after frame_start and falls in the cycle data_valid is high.
- data_valid is high exactly one cycle, the cycle after the clock edge that samples the final stop bit's bit_valid.
- Counters update on the same edge that raises data_valid.
- There is no minimum spacing between bit_valid pulses. Back-to-back strobes on consecutive cycles are accepted.
- A new frame_start is accepted in the cycle after data_valid.

## Test plan
- Even parity, 8N1-style with parity: cfg 8 bits, par_en=1, mode 00, one stop bit; send 0xA5 (parity bit 0, stop bit 1) -> rx_data=0xA5, par_err=0, frm_err=0, data_valid for one cycle.
- Odd parity error: same frame with mode 01 and parity bit 0 -> par_err=1, par_err_cnt 0->1, frm_err=0.
- 5-bit frame, no parity, two stop bits with the second stop bit 0: send 0x13 -> rx_data=0x13, frm_err=1, frm_err_cnt incremented.
- Mark and space modes with parity bit 1: mode 10 gives par_err=0; mode 11 gives par_err=1.
- frame_abort after 3 data bits, then a full 0x3C frame -> one data_valid only, rx_data=0x3C, counters unchanged.
- Saturation and clear with ERR_CNT_W=2
  - Four parity-error frames -> par_err_cnt=3.
  - err_clr in the same cycle as a fifth error's data_valid -> par_err_cnt=0.
  - Reset mid-frame -> all outputs 0, no data_valid.
